// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with blocking miss handling.
// Hits return in one cycle; a miss issues a single word fetch and forwards the fill.
module icache #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_in,
  input  logic        jp_wrong,
  output logic        ins_flag,
  output logic [31:0] ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int DEPTH = 1 << INDEX_W;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state;
  state_t state_next;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic             flush_pend;
  logic             flush_next;
  logic             ins_flag_next;
  logic [31:0]      ins_next;
  logic [31:0]      miss_addr_next;
  logic             fill_we;

  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               unused_bits;

  assign pc_index    = pc_in[INDEX_W+1:2];
  assign pc_tag      = pc_in[31:INDEX_W+2];
  assign fill_index  = mem_addr[INDEX_W+1:2];
  assign fill_tag    = mem_addr[31:INDEX_W+2];
  assign hit         = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign unused_bits = ^pc_in[1:0];

  // mem_addr doubles as the latched miss address, so it is stable for the whole miss.
  assign mem_req = (state == MISS);

  always_comb begin
    state_next     = state;
    flush_next     = flush_pend;
    ins_flag_next  = ins_flag;
    ins_next       = ins;
    miss_addr_next = mem_addr;
    fill_we        = 1'b0;
    case (state)
      IDLE: begin
        flush_next = 1'b0;
        if (jp_wrong) begin
          ins_flag_next = 1'b0;
        end else if (hit) begin
          ins_next      = data_mem[pc_index];
          ins_flag_next = 1'b1;
        end else begin
          ins_flag_next  = 1'b0;
          miss_addr_next = {pc_in[31:2], 2'b00};
          state_next     = MISS;
        end
      end
      MISS: begin
        ins_flag_next = 1'b0;
        if (mem_done) begin
          // The fill always lands; a flush only suppresses forwarding to the fetch stage.
          fill_we    = 1'b1;
          state_next = IDLE;
          flush_next = 1'b0;
          if (!(flush_pend || jp_wrong)) begin
            ins_next      = mem_data;
            ins_flag_next = 1'b1;
          end
        end else if (jp_wrong) begin
          flush_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      ins_flag   <= 1'b0;
      ins        <= 32'h0;
      mem_addr   <= 32'h0;
      valid      <= '0;
    end else if (rdy) begin
      state      <= state_next;
      flush_pend <= flush_next;
      ins_flag   <= ins_flag_next;
      ins        <= ins_next;
      mem_addr   <= miss_addr_next;
      if (fill_we) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem_data;
    end
  end

endmodule
